// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the writeback port arbiter
package wb_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic WB_SRC_PIPE = 1'b0;
  localparam logic WB_SRC_LLU = 1'b1;
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
endpackage

// File: rtl/wb_arb_perf.sv
// wb_arb_perf: three saturating event counters for the writeback arbiter
//  clk, reset (async, active-low)
//  conflict_i / force_i / drop_i : one-cycle increment strobes
//  perf_conflict_o / perf_force_o / perf_drop_o : PERF_W-bit saturating counts
module wb_arb_perf #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conflict_i,
  input  logic              force_i,
  input  logic              drop_i,
  output logic [PERF_W-1:0] perf_conflict_o,
  output logic [PERF_W-1:0] perf_force_o,
  output logic [PERF_W-1:0] perf_drop_o
);
  logic [PERF_W-1:0] conflict_q, force_q, drop_q;
  logic [PERF_W-1:0] conflict_d, force_d, drop_d;
  always_comb begin
    conflict_d = conflict_q + PERF_W'(conflict_i && !(&conflict_q));
    force_d    = force_q + PERF_W'(force_i && !(&force_q));
    drop_d     = drop_q + PERF_W'(drop_i && !(&drop_q));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= '0;
      force_q    <= '0;
      drop_q     <= '0;
    end else begin
      conflict_q <= conflict_d;
      force_q    <= force_d;
      drop_q     <= drop_d;
    end
  end
  assign perf_conflict_o = conflict_q;
  assign perf_force_o    = force_q;
  assign perf_drop_o     = drop_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port between MEM/WB and a long-latency unit
//  clk, reset (async, active-low)
//  pipe_rw/pipe_rd/pipe_data : MEM/WB write request (has priority)
//  llu_valid/llu_rd/llu_data : pending LLU result, held until llu_ready
//  llu_ready  : LLU result granted or dropped this cycle (combinational)
//  pipe_stall : pipeline hold while a starved LLU result is forced through
//  rf_we/rf_waddr/rf_wdata/wb_src : registered regfile write and its source
//  perf_conflict/perf_force/perf_drop : event counters, present only with WB_PERF_EN
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN = 32
`ifdef WB_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_rw,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  llu_valid,
  input  logic [REG_ADDR_W-1:0] llu_rd,
  input  logic [XLEN-1:0]       llu_data,
  output logic                  llu_ready,
  output logic                  pipe_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  wb_src
`ifdef WB_PERF_EN
  , output logic [PERF_W-1:0]   perf_conflict
  , output logic [PERF_W-1:0]   perf_force
  , output logic [PERF_W-1:0]   perf_drop
`endif
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rf_we_q, rf_we_d, wb_src_q, wb_src_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic pipe_wr, llu_live, same_rd, grant_pipe, grant_llu, drop;
  assign pipe_wr  = pipe_rw && pipe_rd != '0;
  assign llu_live = llu_valid && llu_rd != '0;
  assign same_rd  = pipe_wr && llu_live && pipe_rd == llu_rd;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_pipe = 1'b0;
    grant_llu  = 1'b0;
    drop       = 1'b0;
    case (state_q)
      IDLE: begin
        grant_pipe = pipe_wr;
        grant_llu  = llu_live && !pipe_wr;
        drop       = same_rd;
        if (llu_live && pipe_wr && !same_rd) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        grant_pipe = pipe_wr;
        grant_llu  = llu_live && !pipe_wr;
        drop       = same_rd;
        if (!llu_live || !pipe_wr || same_rd) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STARVE_LIMIT)) begin
          state_d = FORCE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FORCE: begin
        // MEM/WB is frozen and re-presents its request, so only the LLU writes here
        grant_llu = llu_live;
        state_d   = IDLE;
        cnt_d     = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    rf_we_d    = grant_pipe || grant_llu;
    wb_src_d   = grant_llu ? WB_SRC_LLU : WB_SRC_PIPE;
    rf_waddr_d = grant_llu ? llu_rd : grant_pipe ? pipe_rd : rf_waddr_q;
    rf_wdata_d = grant_llu ? llu_data : grant_pipe ? pipe_data : rf_wdata_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_src_q   <= WB_SRC_PIPE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_src_q   <= wb_src_d;
    end
  end
  // Results for x0 are consumed without a write in every state
  assign llu_ready  = grant_llu || drop || (llu_valid && llu_rd == '0);
  assign pipe_stall = state_q == FORCE;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign wb_src     = wb_src_q;
`ifdef WB_PERF_EN
  wb_arb_perf #(.PERF_W(PERF_W)) u_perf (
    .clk             (clk),
    .reset           (reset),
    .conflict_i      (state_q == WAIT),
    .force_i         (state_q != FORCE && state_d == FORCE),
    .drop_i          (drop),
    .perf_conflict_o (perf_conflict),
    .perf_force_o    (perf_force),
    .perf_drop_o     (perf_drop)
  );
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector and sequence checks for wb_port_arbiter
module tb_wb_port_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic prw = 1'b0, lv = 1'b0;
  logic [4:0] prd = '0, lrd = '0;
  logic [31:0] pdat = '0, ldat = '0;
  logic rdy0, stall0, we0, src0;
  logic [4:0] waddr0;
  logic [31:0] wdata0;
  logic rdy1, stall1, we1, src1;
  logic [4:0] waddr1;
  logic [31:0] wdata1;
`ifdef WB_PERF_EN
  logic [15:0] pc0, pf0, pd0, pc1, pf1, pd1;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  wb_port_arbiter dut0 (
    .clk(clk), .reset(reset), .pipe_rw(prw), .pipe_rd(prd), .pipe_data(pdat),
    .llu_valid(lv), .llu_rd(lrd), .llu_data(ldat), .llu_ready(rdy0), .pipe_stall(stall0),
    .rf_we(we0), .rf_waddr(waddr0), .rf_wdata(wdata0), .wb_src(src0)
`ifdef WB_PERF_EN
    , .perf_conflict(pc0), .perf_force(pf0), .perf_drop(pd0)
`endif
  );
  wb_port_arbiter #(.STARVE_LIMIT(1)) dut1 (
    .clk(clk), .reset(reset), .pipe_rw(prw), .pipe_rd(prd), .pipe_data(pdat),
    .llu_valid(lv), .llu_rd(lrd), .llu_data(ldat), .llu_ready(rdy1), .pipe_stall(stall1),
    .rf_we(we1), .rf_waddr(waddr1), .rf_wdata(wdata1), .wb_src(src1)
`ifdef WB_PERF_EN
    , .perf_conflict(pc1), .perf_force(pf1), .perf_drop(pd1)
`endif
  );
  typedef struct {
    logic prw; logic [4:0] prd; logic [31:0] pdat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic e_rdy; logic e_we; logic [4:0] e_addr; logic [31:0] e_dat; logic e_src;
  } vec_t;
  vec_t v[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic a, input logic [4:0] b, input logic [31:0] c,
                       input logic d, input logic [4:0] e, input logic [31:0] f);
    prw = a; prd = b; pdat = c; lv = d; lrd = e; ldat = f;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0] = '{1'b1, 5'd5,  32'hAA,   1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 5'd5,  32'hAA,   1'b0};
    v[1] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h1234, 1'b1, 1'b1, 5'd7,  32'h1234, 1'b1};
    v[2] = '{1'b1, 5'd3,  32'h33,   1'b1, 5'd3,  32'h44,   1'b1, 1'b1, 5'd3,  32'h33,   1'b0};
    v[3] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'h77,   1'b1, 1'b0, 5'd0,  32'h0,    1'b0};
    v[4] = '{1'b1, 5'd0,  32'h88,   1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 5'd0,  32'h0,    1'b0};
    v[5] = '{1'b0, 5'd5,  32'h99,   1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 5'd0,  32'h0,    1'b0};
    v[6] = '{1'b1, 5'd0,  32'h11,   1'b1, 5'd12, 32'h55,   1'b1, 1'b1, 5'd12, 32'h55,   1'b1};
    v[7] = '{1'b1, 5'd31, 32'hBEEF, 1'b1, 5'd0,  32'h66,   1'b1, 1'b1, 5'd31, 32'hBEEF, 1'b0};
    v[8] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 5'd0,  32'h0,    1'b0};
    #2;
    chk("rst_we", {31'd0, we0}, 0);
    chk("rst_waddr", {27'd0, waddr0}, 0);
    chk("rst_wdata", wdata0, 0);
    chk("rst_src", {31'd0, src0}, 0);
    chk("rst_stall", {31'd0, stall0}, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(v[i].prw, v[i].prd, v[i].pdat, v[i].lv, v[i].lrd, v[i].ldat);
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, rdy0}, {31'd0, v[i].e_rdy});
      tick();
      chk($sformatf("v%0d_we", i), {31'd0, we0}, {31'd0, v[i].e_we});
      chk($sformatf("v%0d_stall", i), {31'd0, stall0}, 0);
      if (v[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), {27'd0, waddr0}, {27'd0, v[i].e_addr});
        chk($sformatf("v%0d_wdata", i), wdata0, v[i].e_dat);
        chk($sformatf("v%0d_src", i), {31'd0, src0}, {31'd0, v[i].e_src});
      end
    end
`ifdef WB_PERF_EN
    chk("perf_drop_table", {16'd0, pd0}, 1);
    chk("perf_force_table", {16'd0, pf0}, 0);
`endif
    // starvation: pipe writes every cycle while x9 waits; pipe rd 15 is held across FORCE
    for (int c = 0; c <= 6; c++) begin
      drive(1'b1, 5'(10 + (c > 5 ? 5 : c)), 32'h100 + (c > 5 ? 5 : c), c <= 5, 5'd9, 32'h99);
      #1;
      chk($sformatf("starve%0d_stall", c), {31'd0, stall0}, {31'd0, c == 5});
      chk($sformatf("starve%0d_ready", c), {31'd0, rdy0}, {31'd0, c == 5});
      chk($sformatf("starve%0d_stall_l1", c), {31'd0, stall1}, {31'd0, c == 2 || c == 5});
      tick();
      chk($sformatf("starve%0d_we", c), {31'd0, we0}, 1);
      chk($sformatf("starve%0d_waddr", c), {27'd0, waddr0}, c == 5 ? 9 : 10 + (c > 5 ? 5 : c));
      chk($sformatf("starve%0d_wdata", c), wdata0, c == 5 ? 32'h99 : 32'h100 + (c > 5 ? 5 : c));
      chk($sformatf("starve%0d_src", c), {31'd0, src0}, {31'd0, c == 5});
    end
    // llu_valid withdrawn in WAIT: count restarts, FORCE only after four fresh WAIT cycles
    for (int c = 0; c <= 8; c++) begin
      drive(1'b1, 5'd20, 32'h200, c != 2, 5'd4, 32'h44);
      #1;
      chk($sformatf("viol%0d_stall", c), {31'd0, stall0}, {31'd0, c == 8});
      chk($sformatf("viol%0d_ready", c), {31'd0, rdy0}, {31'd0, c == 8});
      tick();
    end
`ifdef WB_PERF_EN
    chk("perf_conflict", {16'd0, pc0}, 10);
    chk("perf_force", {16'd0, pf0}, 2);
    chk("perf_drop", {16'd0, pd0}, 1);
`endif
    // async reset while in FORCE
    for (int c = 0; c <= 4; c++) begin
      drive(1'b1, 5'd21, 32'h300, 1'b1, 5'd8, 32'h88);
      tick();
    end
    #1;
    chk("rf_force_stall", {31'd0, stall0}, 1);
    reset = 1'b0;
    #1;
    chk("rf_rst_stall", {31'd0, stall0}, 0);
    chk("rf_rst_we", {31'd0, we0}, 0);
    chk("rf_rst_src", {31'd0, src0}, 0);
`ifdef WB_PERF_EN
    chk("rf_rst_perf", {16'd0, pc0 | pf0 | pd0}, 0);
`endif
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    #1;
    chk("post_rst_ready", {31'd0, rdy0}, 1);
    tick();
    chk("post_rst_stall", {31'd0, stall0}, 0);
    chk("post_rst_we", {31'd0, we0}, 1);
    chk("post_rst_waddr", {27'd0, waddr0}, 6);
    chk("post_rst_src", {31'd0, src0}, 1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("idle_we", {31'd0, we0}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
